// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering RV32I byte/half/word loads and stores
// after a fixed number of wait states, with alignment and range fault reporting.
module dmem_responder #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0] mem [MEM_DEPTH];

    logic        enter_resp;
    logic        a_write;
    logic [31:0] a_addr;
    logic [2:0]  a_funct3;
    logic [31:0] a_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic        err_c;
    logic        out_of_range;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        commit;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request has to be used instead of the captured copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            a_write  = bus.req_write;
            a_addr   = bus.req_addr;
            a_funct3 = bus.req_funct3;
            a_wdata  = bus.req_wdata;
        end else begin
            a_write  = write_q;
            a_addr   = addr_q;
            a_funct3 = funct3_q;
            a_wdata  = wdata_q;
        end
    end

    assign idx          = a_addr[AW+1:2];
    assign rd_word      = mem[idx];
    assign byte_sel     = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign half_sel     = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign out_of_range = ({1'b0, a_addr} >= 33'(64'(MEM_DEPTH) * 64'd4));

    always_comb begin
        err_c    = 1'b0;
        load_val = '0;
        be       = '0;
        wd       = '0;
        case (a_funct3)
            3'b000: begin
                load_val = {{24{byte_sel[7]}}, byte_sel};
                be       = 4'b0001 << a_addr[1:0];
                wd       = {4{a_wdata[7:0]}};
            end
            3'b001: begin
                err_c    = a_addr[0];
                load_val = {{16{half_sel[15]}}, half_sel};
                be       = a_addr[1] ? 4'b1100 : 4'b0011;
                wd       = {2{a_wdata[15:0]}};
            end
            3'b010: begin
                err_c    = (a_addr[1:0] != 2'b00);
                load_val = rd_word;
                be       = '1;
                wd       = a_wdata;
            end
            3'b100: begin
                err_c    = a_write;
                load_val = {24'b0, byte_sel};
            end
            3'b101: begin
                err_c    = a_write | a_addr[0];
                load_val = {16'b0, half_sel};
            end
            default: err_c = 1'b1;
        endcase
        if (out_of_range) err_c = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                write_d  = bus.req_write;
                addr_d   = bus.req_addr;
                funct3_d = bus.req_funct3;
                wdata_d  = bus.req_wdata;
                if (WAIT_CYCLES == 0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(WAIT_CYCLES);
                end
            end
            S_WAIT: if (cnt_q <= CW'(1)) begin
                state_d    = S_RESP;
                cnt_d      = '0;
                enter_resp = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = err_c;
            rdata_d = (a_write || err_c) ? '0 : load_val;
        end
    end

    assign commit = enter_resp & a_write & ~err_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) & ~rst;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-built stall/reset
// sequences, and random traffic against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned WC    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .MEM_DEPTH   (DEPTH),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [7:0] mem_b [0:4*DEPTH-1];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", nm, got, exp);
    endtask

    // Reference: little-endian byte memory, access size and signedness from funct3.
    function automatic void model(input bit w, input logic [31:0] a, input logic [2:0] f,
                                  input logic [31:0] d, output logic [31:0] rd, output bit er);
        int unsigned size;
        bit sgn;
        rd = '0;
        size = 0;
        sgn = 1'b0;
        case (f)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd5: begin size = 2; sgn = 1'b0; end
            3'd2: begin size = 4; sgn = 1'b0; end
            default: size = 0;
        endcase
        er = (size == 0);
        if (!er) er = (w && (f == 3'd4 || f == 3'd5)) || ((a % size) != 0) || (a >= 4 * DEPTH);
        if (er) return;
        if (w) begin
            for (int unsigned i = 0; i < size; i++) mem_b[a + i] = d[8*i +: 8];
        end else begin
            for (int unsigned i = 0; i < size; i++) rd[8*i +: 8] = mem_b[a + i];
            if (sgn && rd[8*size - 1])
                for (int unsigned j = size; j < 4; j++) rd[8*j +: 8] = 8'hFF;
        end
    endfunction

    task automatic xact(input bit w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        rd = '0;
        er = 1'b0;
        lat = -1;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_funct3 = f;
        bus.req_wdata  = d;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            check("req_ready timeout", {31'b0, bus.req_ready}, 32'd1);
            return;
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_funct3 = 3'($urandom);
        bus.req_wdata  = $urandom;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        if (bus.rsp_valid !== 1'b1) begin
            check("rsp_valid timeout", {31'b0, bus.rsp_valid}, 32'd1);
            return;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    vec_t vecs [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, mrd;
        logic        er;
        bit          mer;
        int          lat, n;
        bit          w;
        logic [2:0]  f;
        logic [31:0] a, d;
        int unsigned r;

        vecs.push_back('{1'b1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h11,  3'd0, 32'h00000080, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h11,  3'd0, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 32'h11,  3'd4, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h22,  3'd1, 32'h00008001, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h22,  3'd1, 32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 32'h22,  3'd5, 32'h0,        32'h00008001, 1'b0});
        vecs.push_back('{1'b0, 32'h21,  3'd1, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h400, 3'd2, 32'hCAFEF00D, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h13,  3'd2, 32'hCAFEF00D, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h10,  3'd4, 32'h000000AA, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h10,  3'd7, 32'h00000000, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h3FC, 3'd2, 32'h12345678, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h3FC, 3'd2, 32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 32'h3FF, 3'd0, 32'h0,        32'h00000012, 1'b0});
        vecs.push_back('{1'b0, 32'h3FE, 3'd5, 32'h0,        32'h00001234, 1'b0});
        vecs.push_back('{1'b0, 32'h400, 3'd4, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'hFFFFFFF0, 3'd2, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h10,  3'd6, 32'h0,        32'h0,        1'b1});

        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'd2;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_err",   {31'b0, bus.rsp_err},   32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("req_ready after reset", {31'b0, bus.req_ready}, 32'd1);
        check("rsp_valid after reset", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);

        foreach (vecs[i]) begin
            xact(vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].d, rd, er, lat);
            model(vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].d, mrd, mer);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(WC + 1));
        end

        // Backpressure: response held 5 cycles while a second request waits.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10; bus.req_funct3 = 3'd2;
        @(negedge clk);
        bus.req_addr = 32'h3FC;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check("stall rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("stall rsp_rdata", bus.rsp_rdata, 32'hDEAD80EF);
            check("stall req_ready", {31'b0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post-stall rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("post-stall req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        check("second req latency", 32'(lat), 32'(WC + 1));
        check("second req rdata", bus.rsp_rdata, 32'h12345678);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Reset during WAIT discards an uncommitted store.
        xact(1'b1, 32'h30, 3'd2, 32'h11111111, rd, er, lat);
        model(1'b1, 32'h30, 3'd2, 32'h11111111, mrd, mer);
        check("sw 0x30 err", {31'b0, er}, 32'd0);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30;
        bus.req_funct3 = 3'd2; bus.req_wdata = 32'h22222222;
        check("abort accept ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort req_ready in rst", {31'b0, bus.req_ready}, 32'd0);
        check("abort rsp_valid in rst", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort no response", {31'b0, bus.rsp_valid}, 32'd0);
        end
        xact(1'b0, 32'h30, 3'd2, 32'h0, rd, er, lat);
        check("abort lw 0x30", rd, 32'h11111111);

        // Random traffic over a pre-written window plus out-of-range addresses.
        for (int unsigned k = 0; k < 16; k++) begin
            d = $urandom;
            xact(1'b1, 32'(4*k), 3'd2, d, rd, er, lat);
            model(1'b1, 32'(4*k), 3'd2, d, mrd, mer);
            check("init err", {31'b0, er}, 32'd0);
        end
        for (int k = 0; k < 300; k++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 15));
            else if (r == 1) a = 32'h80000000 | $urandom;
            else             a = 32'($urandom_range(0, 63));
            d = $urandom;
            xact(w, a, f, d, rd, er, lat);
            model(w, a, f, d, mrd, mer);
            check($sformatf("rand%0d w=%0d f=%0d a=%08h rdata", k, w, f, a), rd, mrd);
            check($sformatf("rand%0d err", k), {31'b0, er}, {31'b0, mer});
            check($sformatf("rand%0d latency", k), 32'(lat), 32'(WC + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
